sifive_insight_tl_b_capture: RTL and testbench
==============================================

// Module: sifive_insight_tl_b_capture
// PURPOSE
//  Parametrised TileLink B-channel trace capture for the Insight debug path, one instance per hart/port.
//  Passively snoops B-channel handshakes, keeps fired beats that pass the opcode filter, and stamps each with
//  a cycle timestamp. Buffers the records in a FIFO for the trace encoder. On overflow it counts lost beats
//  and emits a loss-marker record.
// PARAMETERS
//  DATA_W    32  B-channel data width; a multiple of 8 (mask width = DATA_W/8)
//  ADDR_W    32  address width
//  SOURCE_W  1   source-ID width
//  SIZE_W    4   size-field width
//  DEPTH     8   FIFO entries; a power of 2, >=2
//  TS_W      16  timestamp width
//  CNT_W     8   lost-beat counter width
// PORTS
//  clock            in   1            single clock domain
//  reset            in   1            asynchronous, active-high
//  b_ready          in   1            snooped channel ready
//  b_valid          in   1            snooped channel valid
//  b_opcode         in   3            B opcode
//  b_param          in   2            B param
//  b_size           in   SIZE_W       B size
//  b_source         in   SOURCE_W     B source
//  b_address        in   ADDR_W       B address
//  b_mask           in   DATA_W/8     B mask
//  b_data           in   DATA_W       B data
//  b_corrupt        in   1            B corrupt
//  cfg_enable       in   1            capture enable
//  cfg_opcode_mask  in   8            bit k=1 keeps opcode k
//  out_valid        out  1            a record is available
//  out_ready        in   1            consumer accepts the record
//  out_record       out  rec_t width  head record (packed struct; see STRUCTURE)
//  stat_lost_total  out  CNT_W        saturating count of all lost beats since reset
// BEHAVIOUR
//  Reset values: out_valid=0, out_record=0, stat_lost_total=0, timestamp=0, lost=0, FIFO empty, state=OFF.
//  hit = b_valid & b_ready & cfg_enable & cfg_opcode_mask[b_opcode]; inputs are sampled on this cycle only.
//  Timestamp: free-running TS_W counter, +1 per cycle while cfg_enable=1, held while 0, wraps 2^TS_W-1 -> 0.
//   Each record carries the timestamp value of its hit cycle.
//  FIFO: first-word fall-through, at most one write and one read per cycle. A record written at edge N shows
//   out_valid=1 after edge N (latency 1). A pop occurs when out_valid & out_ready.
//  Fullness: a write is accepted when not full, or when full and a pop happens in the same cycle
//   (occupancy unchanged). Empty with push and no pop -> out_valid=1 next cycle.
//  FSM:
//   OFF  -> RUN  when cfg_enable=1.
//   RUN  -> OFF  when cfg_enable=0.
//   RUN, hit, write accepted -> data record (is_marker=0).
//   RUN, hit, write refused  -> lost=1, go to LOST.
//   LOST: each cycle a write is possible, write a marker record (is_marker=1, lost_cnt=lost, data fields 0,
//    ts=current).
//    - If no hit that cycle: lost:=0, go to RUN, or to OFF if cfg_enable=0.
//    - If a hit coincides with the marker write: the hit is lost, lost:=1, stay in LOST.
//    - If a write is impossible and a hit occurs: lost += 1, saturating at 2^CNT_W-1.
//   cfg_enable=0 in LOST: no new hits; the marker is still emitted, then OFF.
//  stat_lost_total increments with every lost beat and saturates.
//  Reset mid-operation: FIFO contents and counters are discarded immediately (asynchronous).
//  The block never drives the B channel; it is observation-only.
// STRUCTURE
//  Package sifive_insight_tl_pkg:
//   - tl_b_opcode_e: PutFull=0, PutPartial=1, Arith=2, Logic=3, Get=4, Hint=5, Probe=6.
//   - capture_state_e: OFF/RUN/LOST.
//   - parameterised rec_t struct: ts, is_marker, lost_cnt, opcode, param, size, source, address, mask,
//     data, corrupt.
//  Sub-module: sifive_insight_sync_fifo (WIDTH, DEPTH; FWFT; push/pop/full/empty; async active-high reset).
//  Top level holds the filter, the timestamp counter, the FSM and the loss counters.
// TESTING
//  1 Pass-through: mask=8'h40, Probe beat (addr 0x8000_0040, param 2) at ts=5, out_ready=1 ->
//    one record with ts=5, opcode=6, param=2, out_valid asserted one cycle later.
//  2 Filter: mask=8'h40; Get (opcode 4) and valid-without-ready beats -> no record;
//    stat_lost_total stays 0.
//  3 Overflow: DEPTH=8, out_ready=0, 11 Probe hits -> 8 data records, then lost=3.
//    With out_ready=1 and no hits: marker with lost_cnt=3 follows record 8, stat_lost_total=3.
//  4 Full with simultaneous pop: FIFO full, pop and hit in the same cycle -> hit accepted,
//    occupancy stays 8, no loss.
//  5 Marker collision: in LOST, a hit arrives in the marker-write cycle -> marker written,
//    new lost=1, second marker with lost_cnt=1 later.
//  6 Wrap and reset: TS_W=4, hit at ts=15 and the next cycle -> ts 15 then 0. Assert reset mid-burst ->
//    out_valid=0 immediately, counters 0.

Source files
------------

// File: rtl/sifive_insight_tl_pkg.sv
// Shared types for the Insight TileLink B-channel trace capture path.
// The record layout depends on instance parameters, so it is declared in each user.
package sifive_insight_tl_pkg;

    typedef enum logic [2:0] {
        PutFull    = 3'd0,
        PutPartial = 3'd1,
        Arith      = 3'd2,
        Logic      = 3'd3,
        Get        = 3'd4,
        Hint       = 3'd5,
        Probe      = 3'd6
    } tl_b_opcode_e;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        LOST = 2'd2
    } capture_state_e;

    // Packed width of a trace record: ts, is_marker, lost_cnt, opcode, param,
    // size, source, address, mask, data, corrupt.
    function automatic int recWidth(input int tsW, input int cntW, input int sizeW,
                                    input int sourceW, input int addrW, input int dataW);
        return tsW + 1 + cntW + 3 + 2 + sizeW + sourceW + addrW + dataW / 8 + dataW + 1;
    endfunction

endpackage

// File: rtl/sifive_insight_sync_fifo.sv
// First-word fall-through synchronous FIFO; a push is accepted while full if a pop
// happens in the same cycle. Head data reads as zero while empty.
module sifive_insight_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0]   count;
    logic             doPush;
    logic             doPop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign doPop   = pop && !empty;
    assign doPush  = push && (!full || doPop);
    assign popData = empty ? '0 : mem[rdPtr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            if (doPush && !doPop)      count <= count + 1'b1;
            else if (doPop && !doPush) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/sifive_insight_tl_b_capture.sv
// TileLink B-channel trace capture: filters fired beats, timestamps them, queues
// records for the trace encoder and reports overflow losses with marker records.
module sifive_insight_tl_b_capture
    import sifive_insight_tl_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int SOURCE_W = 1,
    parameter int SIZE_W   = 4,
    parameter int DEPTH    = 8,
    parameter int TS_W     = 16,
    parameter int CNT_W    = 8,
    localparam int REC_W   = recWidth(TS_W, CNT_W, SIZE_W, SOURCE_W, ADDR_W, DATA_W)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  b_ready,
    input  logic                  b_valid,
    input  logic [2:0]            b_opcode,
    input  logic [1:0]            b_param,
    input  logic [SIZE_W-1:0]     b_size,
    input  logic [SOURCE_W-1:0]   b_source,
    input  logic [ADDR_W-1:0]     b_address,
    input  logic [DATA_W/8-1:0]   b_mask,
    input  logic [DATA_W-1:0]     b_data,
    input  logic                  b_corrupt,
    input  logic                  cfg_enable,
    input  logic [7:0]            cfg_opcode_mask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REC_W-1:0]      out_record,
    output logic [CNT_W-1:0]      stat_lost_total
);
    typedef struct packed {
        logic [TS_W-1:0]     ts;
        logic                is_marker;
        logic [CNT_W-1:0]    lost_cnt;
        tl_b_opcode_e        opcode;
        logic [1:0]          param;
        logic [SIZE_W-1:0]   size;
        logic [SOURCE_W-1:0] source;
        logic [ADDR_W-1:0]   address;
        logic [DATA_W/8-1:0] mask;
        logic [DATA_W-1:0]   data;
        logic                corrupt;
    } rec_t;

    capture_state_e   state;
    logic [TS_W-1:0]  tsCnt;
    logic [CNT_W-1:0] lostCnt;
    logic [CNT_W-1:0] lostTotal;
    logic             hit;
    logic             fifoFull;
    logic             fifoEmpty;
    logic             pop;
    logic             canWrite;
    logic             push;
    rec_t             pushRec;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign hit             = b_valid & b_ready & cfg_enable & cfg_opcode_mask[b_opcode];
    assign pop             = !fifoEmpty & out_ready;
    assign canWrite        = !fifoFull | pop;
    assign out_valid       = !fifoEmpty;
    assign stat_lost_total = lostTotal;

    always_comb begin
        pushRec    = '0;
        push       = 1'b0;
        pushRec.ts = tsCnt;
        unique case (state)
            RUN: begin
                if (hit && canWrite) begin
                    push            = 1'b1;
                    pushRec.opcode  = tl_b_opcode_e'(b_opcode);
                    pushRec.param   = b_param;
                    pushRec.size    = b_size;
                    pushRec.source  = b_source;
                    pushRec.address = b_address;
                    pushRec.mask    = b_mask;
                    pushRec.data    = b_data;
                    pushRec.corrupt = b_corrupt;
                end
            end
            LOST: begin
                if (canWrite) begin
                    push              = 1'b1;
                    pushRec.is_marker = 1'b1;
                    pushRec.lost_cnt  = lostCnt;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= OFF;
            tsCnt     <= '0;
            lostCnt   <= '0;
            lostTotal <= '0;
        end else begin
            if (cfg_enable) tsCnt <= tsCnt + 1'b1;
            unique case (state)
                OFF: begin
                    if (cfg_enable) state <= RUN;
                end
                RUN: begin
                    if (!cfg_enable) begin
                        state <= OFF;
                    end else if (hit && !canWrite) begin
                        lostCnt   <= CNT_W'(1);
                        lostTotal <= satInc(lostTotal);
                        state     <= LOST;
                    end
                end
                LOST: begin
                    // A hit landing in the marker-write cycle starts a fresh loss run.
                    if (canWrite) begin
                        if (hit) begin
                            lostCnt   <= CNT_W'(1);
                            lostTotal <= satInc(lostTotal);
                        end else begin
                            lostCnt <= '0;
                            state   <= cfg_enable ? RUN : OFF;
                        end
                    end else if (hit) begin
                        lostCnt   <= satInc(lostCnt);
                        lostTotal <= satInc(lostTotal);
                    end
                end
                default: state <= OFF;
            endcase
        end
    end

    sifive_insight_sync_fifo #(
        .WIDTH(REC_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .pushData(pushRec),
        .pop     (pop),
        .popData (out_record),
        .full    (fifoFull),
        .empty   (fifoEmpty)
    );

endmodule

// File: tb/tb_sifive_insight_tl_b_capture.sv
// Self-checking bench for sifive_insight_tl_b_capture: vector table, directed corner
// sequences and a randomized phase, all compared against a queue-based model.
module tb_sifive_insight_tl_b_capture;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int SOURCE_W = 1;
    localparam int SIZE_W   = 4;
    localparam int DEPTH    = 8;
    localparam int TS_W     = 4;
    localparam int CNT_W    = 8;
    localparam int MASK_W   = DATA_W / 8;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [TS_W-1:0]     ts;
        logic                is_marker;
        logic [CNT_W-1:0]    lost_cnt;
        logic [2:0]          opcode;
        logic [1:0]          param;
        logic [SIZE_W-1:0]   size;
        logic [SOURCE_W-1:0] source;
        logic [ADDR_W-1:0]   address;
        logic [MASK_W-1:0]   mask;
        logic [DATA_W-1:0]   data;
        logic                corrupt;
    } rec_t;
    localparam int REC_W = $bits(rec_t);

    typedef struct {
        bit          en;
        bit          v;
        bit          r;
        logic [2:0]  op;
        logic [1:0]  prm;
        logic [31:0] addr;
        logic [7:0]  omask;
        bit          oready;
    } stim_t;

    typedef struct {
        stim_t           s;
        bit              expValid;
        logic [TS_W-1:0] expTs;
        int              expLost;
    } vec_t;

    logic                clock = 1'b0;
    logic                reset;
    logic                b_ready, b_valid, b_corrupt, cfg_enable, out_valid, out_ready;
    logic [2:0]          b_opcode;
    logic [1:0]          b_param;
    logic [SIZE_W-1:0]   b_size;
    logic [SOURCE_W-1:0] b_source;
    logic [ADDR_W-1:0]   b_address;
    logic [MASK_W-1:0]   b_mask;
    logic [DATA_W-1:0]   b_data;
    logic [7:0]          cfg_opcode_mask;
    logic [REC_W-1:0]    out_record;
    logic [CNT_W-1:0]    stat_lost_total;

    sifive_insight_tl_b_capture #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SOURCE_W(SOURCE_W), .SIZE_W(SIZE_W),
        .DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .b_ready(b_ready), .b_valid(b_valid),
        .b_opcode(b_opcode), .b_param(b_param), .b_size(b_size), .b_source(b_source),
        .b_address(b_address), .b_mask(b_mask), .b_data(b_data), .b_corrupt(b_corrupt),
        .cfg_enable(cfg_enable), .cfg_opcode_mask(cfg_opcode_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_record(out_record),
        .stat_lost_total(stat_lost_total)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: expected record queue, timestamp, pending loss count (0 = none).
    rec_t mq[$];
    rec_t seen[$];
    int   mTs, mLost, mTotal;
    bit   mRun;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void modelReset();
        mq.delete();
        mTs = 0; mLost = 0; mTotal = 0; mRun = 1'b0;
    endfunction

    function automatic int satAdd(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    function automatic void modelStep();
        bit   hit, pop, room;
        rec_t r;
        hit  = b_valid && b_ready && cfg_enable && cfg_opcode_mask[b_opcode];
        pop  = (mq.size() > 0) && out_ready;
        room = (mq.size() < DEPTH) || pop;
        if (pop) void'(mq.pop_front());
        if (mLost > 0) begin
            if (room) begin
                r = '0;
                r.ts = TS_W'(mTs);
                r.is_marker = 1'b1;
                r.lost_cnt = CNT_W'(mLost);
                mq.push_back(r);
                if (hit) begin
                    mLost = 1;
                    mTotal = satAdd(mTotal);
                end else begin
                    mLost = 0;
                    mRun = cfg_enable;
                end
            end else if (hit) begin
                mLost = satAdd(mLost);
                mTotal = satAdd(mTotal);
            end
        end else if (mRun) begin
            if (!cfg_enable) mRun = 1'b0;
            else if (hit) begin
                if (room) begin
                    r = '{ts: TS_W'(mTs), is_marker: 1'b0, lost_cnt: '0, opcode: b_opcode,
                          param: b_param, size: b_size, source: b_source, address: b_address,
                          mask: b_mask, data: b_data, corrupt: b_corrupt};
                    mq.push_back(r);
                end else begin
                    mLost = 1;
                    mTotal = satAdd(mTotal);
                end
            end
        end else begin
            mRun = cfg_enable;
        end
        if (cfg_enable) mTs = (mTs + 1) % (1 << TS_W);
    endfunction

    task automatic checkOutputs(input string tag);
        rec_t e;
        e = (mq.size() > 0) ? mq[0] : '0;
        chk({tag, ".valid"}, 128'(out_valid), 128'(mq.size() > 0));
        chk({tag, ".record"}, 128'(out_record), 128'(e));
        chk({tag, ".lost"}, 128'(stat_lost_total), 128'(mTotal));
    endtask

    task automatic drive(input stim_t s);
        cfg_enable      = s.en;
        b_valid         = s.v;
        b_ready         = s.r;
        b_opcode        = s.op;
        b_param         = s.prm;
        b_address       = s.addr;
        cfg_opcode_mask = s.omask;
        out_ready       = s.oready;
        b_size          = SIZE_W'($urandom);
        b_source        = SOURCE_W'($urandom);
        b_mask          = MASK_W'($urandom);
        b_data          = $urandom;
        b_corrupt       = 1'($urandom);
    endtask

    task automatic preEdge(input stim_t s, input string tag);
        drive(s);
        @(negedge clock);
        checkOutputs(tag);
    endtask

    task automatic postEdge();
        modelStep();
        @(posedge clock);
        #1;
    endtask

    task automatic step(input stim_t s, input string tag);
        preEdge(s, tag);
        postEdge();
    endtask

    function automatic stim_t idleS(input bit oready);
        stim_t s;
        s = '{en: 1'b1, v: 1'b0, r: 1'b1, op: 3'd6, prm: 2'd0, addr: 32'h0,
              omask: 8'h40, oready: oready};
        return s;
    endfunction

    function automatic stim_t hitS(input bit oready);
        stim_t s;
        s = idleS(oready);
        s.v = 1'b1;
        s.prm = 2'd2;
        s.addr = $urandom;
        return s;
    endfunction

    task automatic drain(input string tag);
        seen.delete();
        for (int i = 0; i < DEPTH + 4; i++) begin
            preEdge(idleS(1'b1), tag);
            if (out_valid) seen.push_back(rec_t'(out_record));
            postEdge();
        end
    endtask

    task automatic fill(input int n, input string tag);
        for (int i = 0; i < n; i++) step(hitS(1'b0), tag);
    endtask

    vec_t vec[12];
    rec_t cur;
    int   markers;
    stim_t s;

    initial begin
        reset = 1'b1;
        drive(idleS(1'b0));
        cfg_enable = 1'b0;
        modelReset();
        #1;
        @(negedge clock);
        checkOutputs("reset");
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Pass-through and filter vectors, starting from ts=0 with capture off.
        for (int i = 0; i < 12; i++) vec[i] = '{s: idleS(1'b1), expValid: 1'b0, expTs: '0, expLost: 0};
        vec[5].s  = '{en: 1'b1, v: 1'b1, r: 1'b1, op: 3'd6, prm: 2'd2, addr: 32'h8000_0040,
                      omask: 8'h40, oready: 1'b1};
        vec[6].expValid = 1'b1;
        vec[6].expTs    = 4'd5;
        vec[8].s.v  = 1'b1;
        vec[8].s.op = 3'd4;
        vec[9].s.v  = 1'b1;
        vec[9].s.r  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            preEdge(vec[i].s, "vec");
            cur = out_record;
            chk("vecValid", 128'(out_valid), 128'(vec[i].expValid));
            if (vec[i].expValid) begin
                chk("vecTs", 128'(cur.ts), 128'(vec[i].expTs));
                chk("vecOpcode", 128'(cur.opcode), 128'(3'd6));
                chk("vecParam", 128'(cur.param), 128'(2'd2));
                chk("vecAddr", 128'(cur.address), 128'(32'h8000_0040));
            end
            chk("vecLost", 128'(stat_lost_total), 128'(vec[i].expLost));
            postEdge();
        end

        // Overflow: 11 hits into an 8-deep FIFO with no consumer.
        fill(11, "ovf");
        drain("ovfDrain");
        chk("ovfCount", 128'(seen.size()), 128'(9));
        if (seen.size() >= 9) begin
            chk("ovfLastData", 128'(seen[7].is_marker), 128'(1'b0));
            chk("ovfMarker", 128'(seen[8].is_marker), 128'(1'b1));
            chk("ovfMarkerCnt", 128'(seen[8].lost_cnt), 128'(8'd3));
        end
        chk("ovfTotal", 128'(stat_lost_total), 128'(8'd3));

        // Full FIFO with a pop and a hit in the same cycle.
        fill(8, "fullFill");
        step(hitS(1'b1), "fullPop");
        drain("fullDrain");
        chk("fullCount", 128'(seen.size()), 128'(8));
        markers = 0;
        foreach (seen[i]) if (seen[i].is_marker) markers++;
        chk("fullNoMarker", 128'(markers), 128'(0));
        chk("fullTotal", 128'(stat_lost_total), 128'(8'd3));

        // Hit colliding with the marker-write cycle.
        fill(9, "colFill");
        step(hitS(1'b1), "colHit");
        drain("colDrain");
        chk("colCount", 128'(seen.size()), 128'(9));
        markers = 0;
        foreach (seen[i]) if (seen[i].is_marker && seen[i].lost_cnt == 8'd1) markers++;
        chk("colMarkers", 128'(markers), 128'(2));
        chk("colTotal", 128'(stat_lost_total), 128'(8'd5));

        // Randomized traffic with occasional enable toggles and mask changes.
        s = idleS(1'b1);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 3) s.en = !s.en;
            if (i % 50 == 0) s.omask = 8'($urandom);
            s.v      = 1'($urandom);
            s.r      = ($urandom_range(0, 9) < 7);
            s.op     = 3'($urandom);
            s.prm    = 2'($urandom);
            s.addr   = $urandom;
            s.oready = ($urandom_range(0, 9) < 3);
            step(s, "rand");
        end
        for (int i = 0; i < 20; i++) step(idleS(1'b1), "flush");

        // Timestamp wrap: hits at ts=15 and the following cycle.
        for (int i = 0; i < 20 && mTs != 15; i++) step(idleS(1'b1), "wrapWait");
        step(hitS(1'b0), "wrapA");
        step(hitS(1'b0), "wrapB");
        drain("wrapDrain");
        chk("wrapCount", 128'(seen.size()), 128'(2));
        if (seen.size() >= 2) begin
            chk("wrapTs0", 128'(seen[0].ts), 128'(4'd15));
            chk("wrapTs1", 128'(seen[1].ts), 128'(4'd0));
        end

        // Asynchronous reset in the middle of a burst.
        fill(3, "rstFill");
        drive(hitS(1'b0));
        #2 reset = 1'b1;
        #1;
        chk("rstValid", 128'(out_valid), 128'(1'b0));
        chk("rstRecord", 128'(out_record), 128'(0));
        chk("rstLost", 128'(stat_lost_total), 128'(0));
        drive(idleS(1'b0));
        cfg_enable = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        modelReset();
        @(posedge clock);
        #1;
        for (int i = 0; i < 8; i++) step(hitS(1'b1), "postRst");
        drain("postRstDrain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
